bus_arb4: RTL and testbench
===========================

BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a grant may wait for s_ready (used only with BUS_ARB4_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port m_valid, input, 4 bits: request valid, bit i belongs to master i.
REQ-005 SHALL have port m_ready, output, 4 bits: transfer-complete strobe per master.
REQ-006 SHALL have port m_addr, input, 128 bits: master i's address on bits [32i+31:32i].
REQ-007 SHALL have port m_wdata, input, 128 bits: write data, packed the same way as m_addr.
REQ-008 SHALL have port m_wstrb, input, 16 bits: master i's write strobe on bits [4i+3:4i]; all-zero means read.
REQ-009 SHALL have port m_rdata, output, 32 bits: s_rdata broadcast to all masters.
REQ-010 SHALL have ports s_valid (output, 1), s_ready (input, 1), s_addr (output, 32), s_rdata (input, 32), s_wdata (output, 32) and s_wstrb (output, 4): the single slave port.
REQ-011 SHALL have port grant, output, 2 bits: index of the current or last granted master, for debug.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE with any m_valid bit set, SHALL pick the requester with the lowest index above the last-granted index, wrapping from 3 to 0; SHALL register it into grant and enter BUSY on the next edge.
REQ-014 In IDLE, s_valid SHALL be 0 and m_ready SHALL be 0; grant latency is exactly one cycle from m_valid to s_valid.
REQ-015 In BUSY, s_valid SHALL equal m_valid[grant], and s_addr, s_wdata and s_wstrb SHALL be the granted master's fields.
REQ-016 In BUSY with s_valid and s_ready both high, m_ready[grant] SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-017 m_ready bits other than m_ready[grant] SHALL be 0 in every cycle.
REQ-018 If m_valid[grant] drops while in BUSY, the FSM SHALL return to IDLE without issuing m_ready (abort); the pointer SHALL still advance.
REQ-019 Each transfer occupies at least two cycles (IDLE then BUSY), so back-to-back requests from different masters SHALL alternate in round-robin order.
REQ-020 A master re-requesting immediately after completion SHALL be served only after all other pending masters.
REQ-021 When m_valid changes during BUSY, the grant SHALL NOT change.

Reset
REQ-022 While resetn is low: state SHALL be IDLE, grant SHALL be 3 (so master 0 wins first), and s_valid and m_ready SHALL be 0.
REQ-023 Asserting reset mid-transfer SHALL drop s_valid asynchronously; no m_ready SHALL be generated.

Configuration
REQ-024 With macro BUS_ARB4_TIMEOUT_EN defined:
- a counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready;
- on reaching TIMEOUT_CYCLES, the block SHALL pulse m_ready[grant] together with output m_err (1 bit, present only under the macro), drive m_rdata to 32'hDEADBEEF that cycle, and return to IDLE.
REQ-025 Without BUS_ARB4_TIMEOUT_EN, there SHALL be no counter and no m_err port, and BUSY SHALL wait indefinitely.

Structure
REQ-026 Package bus_arb_pkg SHALL hold NUM_M=4, the state encodings (IDLE=1'b0, BUSY=1'b1) and the timeout rdata constant.
REQ-027 The round-robin next-grant selection SHALL be a combinational sub-module, rr_pick4 (inputs: 4-bit request, 2-bit last grant; outputs: 2-bit index, 1-bit any).

Verification
REQ-028 Reset release, m_valid=4'b0001, addr 0x100, s_ready on the 2nd BUSY cycle -> s_addr=0x100, m_ready=4'b0001 for exactly one cycle, grant=0.
REQ-029 m_valid=4'b1111 held with s_ready always 1 -> grants in order 0,1,2,3,0; each m_ready pulse is one cycle, separated by one IDLE cycle.
REQ-030 Master 2 granted with s_ready low, master 1 raises valid -> s_addr stays master 2's; master 1 is served next.
REQ-031 Master 0 granted, m_valid[0] drops before s_ready -> return to IDLE, no m_ready; next grant goes to the next requester after index 0.
REQ-032 With BUS_ARB4_TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready stuck at 0 -> after 8 BUSY cycles, m_ready[grant]=1, m_err=1, m_rdata=0xDEADBEEF.
REQ-033 resetn pulsed low mid-BUSY -> s_valid=0 immediately and grant=3; after release, master 0 is granted first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 4-master bus arbiter (bus_arb4) and its
// round-robin picker (rr_pick4).
package bus_arb_pkg;

    localparam int NUM_M = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Read data returned to a master whose transfer was cut off by the timeout.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: returns the lowest-index requester
// strictly above i_last, wrapping 3 -> 0. i_last itself is considered last.
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_idx,
    output logic       o_any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [1:0] w_cand;
        o_any  = |i_req;
        o_idx  = i_last;
        w_cand = i_last;
        for (int k = NUM_M; k >= 1; k--) begin
            w_cand = i_last + 2'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arb4.sv
// bus_arb4: round-robin arbiter, four masters onto one slave port.
// Two-state FSM (IDLE picks and registers a grant, BUSY forwards the granted
// master's request until s_ready or until the master withdraws).
// Optional feature: define BUS_ARB4_TIMEOUT_EN to add a stall timeout that
// completes the transfer with m_err and TIMEOUT_RDATA after TIMEOUT_CYCLES.
module bus_arb4
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [3:0]   m_valid,
    output logic [3:0]   m_ready,
    input  logic [127:0] m_addr,
    input  logic [127:0] m_wdata,
    input  logic [15:0]  m_wstrb,
    output logic [31:0]  m_rdata,
    output logic         s_valid,
    input  logic         s_ready,
    output logic [31:0]  s_addr,
    input  logic [31:0]  s_rdata,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
`ifdef BUS_ARB4_TIMEOUT_EN
    output logic         m_err,
`endif
    output logic [1:0]   grant
);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_grant;
    logic [1:0]  w_pick;
    logic        w_any;
    logic        w_done;
    logic        w_timeout;

    logic [31:0] w_addr  [NUM_M];
    logic [31:0] w_wdata [NUM_M];
    logic [3:0]  w_wstrb [NUM_M];

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_arb4: TIMEOUT_CYCLES must be at least 1");
    end

    // Unpack the per-master fields once so the mux below is a plain index.
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
        assign w_addr[gi]  = m_addr[32*gi +: 32];
        assign w_wdata[gi] = m_wdata[32*gi +: 32];
        assign w_wstrb[gi] = m_wstrb[4*gi +: 4];
    end

    rr_pick4 u_pick (
        .i_req  (m_valid),
        .i_last (r_grant),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    assign grant   = r_grant;
    assign s_addr  = w_addr[r_grant];
    assign s_wdata = w_wdata[r_grant];
    assign s_wstrb = w_wstrb[r_grant];

`ifdef BUS_ARB4_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count stalled BUSY cycles; held at zero in IDLE so each grant starts fresh.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (!s_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th consecutive stalled BUSY cycle.
    assign w_timeout = (r_state == BUSY) && m_valid[r_grant] && !s_ready &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign m_err     = w_timeout;
    assign m_rdata   = w_timeout ? TIMEOUT_RDATA : s_rdata;
`else
    assign w_timeout = 1'b0;
    assign m_rdata   = s_rdata;
`endif

    // State and grant registers; grant only moves when a new request is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= 2'd3;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_pick;
            end
        end
    end

    // Next-state and slave/master handshake decode.
    always_comb begin
        w_state_next = r_state;
        s_valid      = 1'b0;
        w_done       = 1'b0;
        m_ready      = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                s_valid = m_valid[r_grant];
                if (!m_valid[r_grant]) begin
                    w_state_next = IDLE;            // master withdrew: abort silently
                end else if (s_ready || w_timeout) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        m_ready[r_grant] = w_done;
    end

endmodule

// File: tb/tb_bus_arb4.sv
// Directed, table-driven bench for bus_arb4 plus hand-written sequences for
// mid-cycle reset, rdata broadcast and (when enabled) the stall timeout.
`timescale 1ns/1ps
module tb_bus_arb4;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   m_valid;
    logic [3:0]   m_ready;
    logic [127:0] m_addr;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic [31:0]  m_rdata;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_addr;
    logic [31:0]  s_rdata;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [1:0]   grant;
`ifdef BUS_ARB4_TIMEOUT_EN
    logic         m_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr  [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400};
    logic [31:0] exp_wdata [4] = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
    logic [3:0]  exp_wstrb [4] = '{4'hF, 4'h0, 4'hC, 4'h3};

    typedef struct {
        logic       rst_n;
        logic [3:0] mv;
        logic       sr;
        logic       exp_sv;
        logic [3:0] exp_mr;
        logic [1:0] exp_g;
    } vec_t;

    localparam int NVEC = 36;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

`ifdef BUS_ARB4_TIMEOUT_EN
    bus_arb4 #(.TIMEOUT_CYCLES(8)) dut (
`else
    bus_arb4 dut (
`endif
        .clk     (clk),
        .resetn  (resetn),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_rdata (s_rdata),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
`ifdef BUS_ARB4_TIMEOUT_EN
        .m_err   (m_err),
`endif
        .grant   (grant)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // rst_n, m_valid, s_ready | s_valid, m_ready, grant
        vecs[0]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3};  // in reset
        vecs[1]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3};  // IDLE, request m0
        vecs[2]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0};  // BUSY stall
        vecs[3]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0};  // complete
        vecs[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3};  // reset, then all request
        vecs[6]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3};
        vecs[7]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[8]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[9]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
        vecs[10] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1};
        vecs[11] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[12] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2};
        vecs[13] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3};
        vecs[14] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3};
        vecs[15] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};  // wrapped to 0
        vecs[16] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[17] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0};  // m2 requests
        vecs[18] = '{1'b1, 4'b0110, 1'b0, 1'b1, 4'b0000, 2'd2};  // m1 joins, grant holds
        vecs[19] = '{1'b1, 4'b0110, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[20] = '{1'b1, 4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[21] = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 2'd2};
        vecs[22] = '{1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1};  // m1 served next
        vecs[23] = '{1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 2'd1};  // m1 re-requests with m0
        vecs[24] = '{1'b1, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0};  // m0 goes first
        vecs[25] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[26] = '{1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0};
        vecs[27] = '{1'b1, 4'b1010, 1'b0, 1'b0, 4'b0000, 2'd0};  // m0 withdraws: abort
        vecs[28] = '{1'b1, 4'b1010, 1'b1, 1'b0, 4'b0000, 2'd0};  // back in IDLE
        vecs[29] = '{1'b1, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1};  // next after 0 is 1
        vecs[30] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1};
        vecs[31] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd1};
        vecs[32] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2};
        vecs[33] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd3};  // reset mid-BUSY
        vecs[34] = '{1'b1, 4'b0101, 1'b1, 1'b0, 4'b0000, 2'd3};
        vecs[35] = '{1'b1, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0};  // m0 first after reset

        m_addr  = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        m_wdata = {exp_wdata[3], exp_wdata[2], exp_wdata[1], exp_wdata[0]};
        m_wstrb = {exp_wstrb[3], exp_wstrb[2], exp_wstrb[1], exp_wstrb[0]};
        s_rdata = 32'h0;
        resetn  = 1'b0;
        m_valid = 4'b0;
        s_ready = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            resetn  = vecs[i].rst_n;
            m_valid = vecs[i].mv;
            s_ready = vecs[i].sr;
            @(negedge clk);
            $display("[TB] vec %0d rst_n=%b mv=%b sr=%b -> s_valid=%b m_ready=%b grant=%0d s_addr=%h",
                     i, resetn, m_valid, s_ready, s_valid, m_ready, grant, s_addr);
            check($sformatf("vec%0d sv/mr/grant", i),
                  64'({s_valid, m_ready, grant}),
                  64'({vecs[i].exp_sv, vecs[i].exp_mr, vecs[i].exp_g}));
            if (vecs[i].exp_sv) begin
                check($sformatf("vec%0d slave fields", i),
                      64'({s_addr, s_wdata[7:0], s_wstrb}),
                      64'({exp_addr[vecs[i].exp_g], exp_wdata[vecs[i].exp_g][7:0],
                           exp_wstrb[vecs[i].exp_g]}));
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted between edges must drop s_valid without waiting for a clock.
        m_valid = 4'b0010;
        s_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        $display("[TB] async reset mid-BUSY -> s_valid=%b m_ready=%b grant=%0d", s_valid, m_ready, grant);
        check("async reset drop", 64'({s_valid, m_ready, grant}), 64'({1'b0, 4'b0000, 2'd3}));

        // After release master 0 wins over master 1; m_rdata mirrors s_rdata.
        @(posedge clk); #1;
        resetn  = 1'b1;
        m_valid = 4'b0011;
        s_ready = 1'b1;
        s_rdata = 32'h1234_5678;
        cyc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cyc = c + 1;
            if (m_ready != 4'b0) break;
            @(posedge clk); #1;
        end
        $display("[TB] post-reset grant -> m_ready=%b grant=%0d m_rdata=%h after %0d cycles",
                 m_ready, grant, m_rdata, cyc);
        check("post-reset first grant", 64'({m_ready, grant}), 64'({4'b0001, 2'd0}));
        check("post-reset latency", 64'(cyc), 64'd2);
        check("rdata broadcast", 64'(m_rdata), 64'h1234_5678);
        @(posedge clk); #1;
        m_valid = 4'b0;
        s_ready = 1'b0;
        @(posedge clk); #1;

`ifdef BUS_ARB4_TIMEOUT_EN
        // Stuck slave: transfer is closed with m_err in the 8th BUSY cycle.
        m_valid = 4'b0100;
        s_ready = 1'b0;
        s_rdata = 32'h0000_0000;
        @(posedge clk); #1;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc = c + 1;
            if (m_ready != 4'b0) break;
            @(posedge clk); #1;
        end
        $display("[TB] timeout -> busy_cycles=%0d m_ready=%b m_err=%b m_rdata=%h", cyc, m_ready, m_err, m_rdata);
        check("timeout cycle", 64'(cyc), 64'd8);
        check("timeout strobe", 64'({m_ready, m_err}), 64'({4'b0100, 1'b1}));
        check("timeout rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        m_valid = 4'b0;
        @(negedge clk);
        check("timeout returns idle", 64'({s_valid, m_err}), 64'({1'b0, 1'b0}));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
